// File: rtl/router_scheduler_pkg.sv
// Shared definitions for the router scheduler slice.
// Packet layout: [5:4] destination port, [3:0] message nibble.
package router_scheduler_pkg;

  localparam int PORT_HI          = 5;
  localparam int PORT_LO          = 4;
  localparam int MSG_HI           = 3;
  localparam int MSG_LO           = 0;
  localparam int PKT_W            = PORT_HI + 1;
  localparam int NUM_PORTS        = 4;
  localparam int DEF_SEND_CYCLES  = 8;

  typedef logic [PORT_HI-PORT_LO:0] port_t;
  typedef logic [PKT_W-1:0]         pkt_t;

endpackage

// File: rtl/router_scheduler_if.sv
// Bundle of the scheduler's producer-side handshake, router-side issue
// bus and status outputs.
//   master : producer / observer side (drives in_data, in_valid)
//   slave  : scheduler side (drives in_ready, rt_*, status)
// Signals:
//   in_data[5:0], in_valid, in_ready   producer handshake
//   rt_data[5:0], rt_valid             one-cycle issue pulse to the router
//   port_busy[3:0]                     per-port sender busy flags
//   fifo_count                         FIFO occupancy
//   stall_cnt                          saturating head-of-line stall count
interface router_scheduler_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
);
  import router_scheduler_pkg::*;

  pkt_t                   in_data;
  logic                   in_valid;
  logic                   in_ready;
  pkt_t                   rt_data;
  logic                   rt_valid;
  logic [NUM_PORTS-1:0]   port_busy;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [CNT_W-1:0]       stall_cnt;

  modport master (
    output in_data, in_valid,
    input  in_ready, rt_data, rt_valid, port_busy, fifo_count, stall_cnt
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, rt_data, rt_valid, port_busy, fifo_count, stall_cnt
  );

endinterface

// File: rtl/router_scheduler_sync_fifo.sv
// Synchronous FIFO with occupancy count.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   push, wdata    write at tail (caller guarantees not full)
//   pop            drop head (caller guarantees not empty)
//   rdata          current head entry (combinational read)
//   count          number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Pointers wrap naturally; full/empty is judged from count only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/router_scheduler.sv
// Front-end scheduler for the secure router. Buffers 6-bit packets in a
// FIFO and issues the head only when its destination sender is idle,
// preserving strict order (head-of-line blocking).
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   bus.slave  in_data/in_valid/in_ready producer handshake,
//              rt_data/rt_valid one-cycle issue pulse,
//              port_busy, fifo_count, stall_cnt status
module router_scheduler
  import router_scheduler_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int SEND_CYCLES = DEF_SEND_CYCLES,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  router_scheduler_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(SEND_CYCLES);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  // The issue cycle itself is the first busy cycle, hence the minus one.
  localparam logic [BW-1:0] RELOAD   = BW'(SEND_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  pkt_t            head;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  logic            stall;
  port_t           head_port;
  logic            head_free;

  logic [BW-1:0]   busy_cnt [NUM_PORTS];
  pkt_t            rt_data_p0;
  logic            vld_p0;
  logic [CNT_W-1:0] stall_p0;

  assign head_port = head[PORT_HI:PORT_LO];
  assign head_free = (busy_cnt[head_port] == '0);
  // No bypass: a full FIFO refuses input even if it pops this cycle.
  assign push      = bus.in_valid && (count != FULL_CNT);
  assign pop       = (count != '0) && head_free;
  assign stall     = (count != '0) && !head_free;

  sync_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (push),
    .pop   (pop),
    .wdata (bus.in_data),
    .rdata (head),
    .count (count)
  );

  // ---- issue stage: single registered decision per cycle ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0     <= 1'b0;
      rt_data_p0 <= '0;
      stall_p0   <= '0;
      for (int p = 0; p < NUM_PORTS; p++) busy_cnt[p] <= '0;
    end else begin
      vld_p0 <= pop;
      if (pop) rt_data_p0 <= head;
      if (stall) stall_p0 <= sat_inc(stall_p0);
      // Reload on issue wins over the per-cycle decrement.
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (pop && head_port == port_t'(p)) busy_cnt[p] <= RELOAD;
        else if (busy_cnt[p] != '0)          busy_cnt[p] <= busy_cnt[p] - 1'b1;
      end
    end
  end

  always_comb begin
    bus.port_busy = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      bus.port_busy[p] = (busy_cnt[p] != '0) ||
                         (vld_p0 && rt_data_p0[PORT_HI:PORT_LO] == port_t'(p));
    end
  end

  assign bus.in_ready   = (count != FULL_CNT);
  assign bus.rt_data    = rt_data_p0;
  assign bus.rt_valid   = vld_p0;
  assign bus.fifo_count = count;
  assign bus.stall_cnt  = stall_p0;

endmodule

// File: tb/tb_router_scheduler.sv
// Directed testbench for router_scheduler with a queue scoreboard.
module tb_router_scheduler;
  import router_scheduler_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst;

  router_scheduler_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus();

  router_scheduler #(
    .DEPTH       (DEPTH),
    .SEND_CYCLES (8),
    .CNT_W       (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [5:0] exp_q [$];
  int         iss_cyc [$];
  logic [5:0] iss_pkt [$];
  logic [5:0] sb_exp;

  // Scoreboard monitor: every issue pulse must match the next expected packet.
  always @(negedge clk) begin
    if (rst && bus.rt_valid) begin
      iss_cyc.push_back(cyc);
      iss_pkt.push_back(bus.rt_data);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got rt_data=%b, nothing expected", bus.rt_data);
      end else begin
        sb_exp = exp_q.pop_front();
        if (bus.rt_data !== sb_exp) begin
          errors++;
          $display("FAIL sb_data: got rt_data=%b expected %b", bus.rt_data, sb_exp);
        end
      end
    end
  end

  // Occupancy watcher for the full-FIFO test.
  bit watch = 1'b0;
  int maxc = 0;
  int rdy_bad = 0;
  always @(negedge clk) begin
    if (watch) begin
      if (int'(bus.fifo_count) > maxc) maxc = int'(bus.fifo_count);
      if (bus.in_ready !== (bus.fifo_count != 3'd4)) rdy_bad++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds in_valid high until accepted; returns the accepting edge index.
  task automatic send(input logic [5:0] p, output int acc);
    bus.in_data  = p;
    bus.in_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 60; i++) begin
      if (bus.in_ready === 1'b1) begin
        exp_q.push_back(p);
        step(1);
        acc = cyc;
        break;
      end
      step(1);
    end
    if (acc < 0) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: packet %b not accepted, required acceptance", p);
    end
  endtask

  task automatic wait_issues(input int n, input int budget);
    int i = 0;
    while (iss_cyc.size() < n && i < budget) begin
      step(1);
      i++;
    end
    check("issue_count", iss_cyc.size(), n);
  endtask

  task automatic wait_quiet(input int budget);
    int i = 0;
    bus.in_valid = 1'b0;
    while ((bus.fifo_count != 0 || bus.port_busy != 0 || bus.rt_valid) && i < budget) begin
      step(1);
      i++;
    end
    check("quiet", (bus.fifo_count == 0 && bus.port_busy == 0), 1);
  endtask

  task automatic clear_log();
    iss_cyc.delete();
    iss_pkt.delete();
  endtask

  initial begin
    int k, a, nb, s0, k6;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    step(2);

    // Reset state
    check("rst_in_ready",   bus.in_ready,   1);
    check("rst_rt_valid",   bus.rt_valid,   0);
    check("rst_rt_data",    bus.rt_data,    0);
    check("rst_port_busy",  bus.port_busy,  0);
    check("rst_fifo_count", bus.fifo_count, 0);
    check("rst_stall_cnt",  bus.stall_cnt,  0);
    rst = 1'b1;
    step(2);

    // Single packet to port 1: issue one edge after acceptance
    clear_log();
    send(6'b01_1010, k);
    bus.in_valid = 1'b0;
    step(1);
    check("t1_valid", bus.rt_valid,  1);
    check("t1_data",  bus.rt_data,   6'b011010);
    check("t1_busy",  bus.port_busy, 4'b0010);
    // Busy from the issue edge while the counter runs 7..1: seven samples.
    nb = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.port_busy == 4'b0010) nb++;
      step(1);
    end
    check("t1_busy_len", nb, 7);
    check("t1_issue_cyc", iss_cyc.size() > 0 ? iss_cyc[0] : -1, k + 1);
    check("t1_pulses", iss_cyc.size(), 1);

    // Three different ports on consecutive cycles
    clear_log();
    send(6'b00_0001, k);
    send(6'b10_0010, a);
    send(6'b11_0011, a);
    bus.in_valid = 1'b0;
    step(1);
    check("t2_busy", bus.port_busy, 4'b1101);
    wait_issues(3, 20);
    check("t2_first", iss_cyc[0], k + 1);
    check("t2_gap01", iss_cyc[1] - iss_cyc[0], 1);
    check("t2_gap12", iss_cyc[2] - iss_cyc[1], 1);
    wait_quiet(40);

    // Two packets to port 2: pulses 8 apart, 7 stall cycles
    clear_log();
    s0 = int'(bus.stall_cnt);
    send(6'b10_0100, k);
    send(6'b10_0101, a);
    bus.in_valid = 1'b0;
    wait_issues(2, 30);
    check("t3_gap", iss_cyc[1] - iss_cyc[0], 8);
    check("t3_stall", int'(bus.stall_cnt) - s0, 7);
    wait_quiet(40);

    // Head-of-line: port-3 packet waits behind the second port-0 packet
    clear_log();
    s0 = int'(bus.stall_cnt);
    send(6'b00_0110, k);
    send(6'b00_0111, a);
    send(6'b11_1000, a);
    bus.in_valid = 1'b0;
    wait_issues(3, 40);
    check("t4_gap_p0", iss_cyc[1] - iss_cyc[0], 8);
    check("t4_gap_p3", iss_cyc[2] - iss_cyc[1], 1);
    check("t4_port3_last", iss_pkt[2][5:4], 3);
    check("t4_stall", int'(bus.stall_cnt) - s0, 7);
    wait_quiet(40);

    // Full FIFO: six packets to port 1. After p1 pops, p2..p5 fill it;
    // p6 is accepted only the edge after p2 issues (k+9), i.e. at k+10.
    clear_log();
    maxc = 0;
    rdy_bad = 0;
    watch = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      send({2'b01, 4'(i)}, a);
      if (i == 1) k = a;
    end
    send(6'b01_0110, k6);
    bus.in_valid = 1'b0;
    check("t5_p6_accept", k6, k + 10);
    wait_issues(6, 80);
    watch = 1'b0;
    check("t5_max_count", maxc, 4);
    check("t5_ready_rule", rdy_bad, 0);
    wait_quiet(40);

    // Stall counter saturation: 32 packets to port 2 add 31*7 more stalls
    for (int i = 0; i < 32; i++) send({2'b10, 4'(i)}, a);
    bus.in_valid = 1'b0;
    wait_quiet(400);
    check("t6_stall_sat", bus.stall_cnt, 255);

    // Reset mid-burst while an issue pulse is high
    clear_log();
    send(6'b00_1001, k);
    send(6'b00_1010, a);
    bus.in_valid = 1'b0;
    check("t7_pre_valid", bus.rt_valid, 1);
    #1;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("t7_rt_valid",   bus.rt_valid,   0);
    check("t7_fifo_count", bus.fifo_count, 0);
    check("t7_port_busy",  bus.port_busy,  0);
    check("t7_in_ready",   bus.in_ready,   1);
    check("t7_stall_cnt",  bus.stall_cnt,  0);
    check("t7_rt_data",    bus.rt_data,    0);
    step(1);
    rst = 1'b1;
    step(1);
    clear_log();
    // Port 0 must be free again right after reset
    send(6'b00_1011, k);
    bus.in_valid = 1'b0;
    wait_issues(1, 10);
    check("t7_post_issue", iss_cyc[0], k + 1);
    step(3);
    check("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
